// File: rtl/regfile_32x32.sv
// 32 x 32-bit register file with two combinational read ports, optional write-to-read
// forwarding, and a bulk clear sweep that zeroes registers 1..31 one per cycle.
module regfile_32x32 #(
    parameter int BYPASS = 1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] ReadData1,
    output logic [31:0] ReadData2,
    input  logic [31:0] WriteData,
    input  logic [4:0]  ReadRegister1,
    input  logic [4:0]  ReadRegister2,
    input  logic [4:0]  WriteRegister,
    input  logic        RegWrite,
    input  logic        clear_req,
    output logic        busy,
    output logic        clear_done
);

    localparam logic IDLE  = 1'b0;
    localparam logic CLEAR = 1'b1;

    logic        state_reg;
    logic        state_next;
    logic [4:0]  cnt_reg;
    logic [4:0]  cnt_next;
    logic        clear_done_reg;
    logic        clear_done_next;
    logic        write_en;
    logic        bypass1;
    logic        bypass2;
    logic [31:0] rd_arr [0:31];

    assign busy       = (state_reg == CLEAR);
    assign clear_done = clear_done_reg;

    // Writes to r0 are dropped here so the sweep and the write path never touch it.
    assign write_en = RegWrite && !busy && (WriteRegister != 5'd0);

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        clear_done_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (clear_req) begin
                    state_next = CLEAR;
                    cnt_next   = 5'd1;
                end
            end
            default: begin
                if (cnt_reg == 5'd31) begin
                    state_next      = IDLE;
                    cnt_next        = 5'd0;
                    clear_done_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 5'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= 5'd0;
            clear_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            clear_done_reg <= clear_done_next;
        end
    end

    assign rd_arr[0] = 32'd0;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : gen_reg
            logic [31:0] q_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    q_reg <= 32'd0;
                end else if (write_en && (WriteRegister == 5'(gi))) begin
                    q_reg <= WriteData;
                end else if (busy && (cnt_reg == 5'(gi))) begin
                    q_reg <= 32'd0;
                end
            end

            assign rd_arr[gi] = q_reg;
        end
    endgenerate

    // Forwarding is gated by write_en, so it is off during a sweep and for r0.
    assign bypass1 = (BYPASS != 0) && write_en && (WriteRegister == ReadRegister1);
    assign bypass2 = (BYPASS != 0) && write_en && (WriteRegister == ReadRegister2);

    assign ReadData1 = bypass1 ? WriteData : rd_arr[ReadRegister1];
    assign ReadData2 = bypass2 ? WriteData : rd_arr[ReadRegister2];

endmodule

// File: tb/tb_regfile_32x32.sv
// Bench for regfile_32x32: both BYPASS settings driven in parallel, checked each cycle
// against a behavioural model, plus directed scenarios with literal expectations.
module tb_regfile_32x32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] WriteData = 32'd0;
    logic [4:0]  ReadRegister1 = 5'd0;
    logic [4:0]  ReadRegister2 = 5'd0;
    logic [4:0]  WriteRegister = 5'd0;
    logic        RegWrite = 1'b0;
    logic        clear_req = 1'b0;

    logic [31:0] rd1_b1, rd2_b1, rd1_b0, rd2_b0;
    logic        busy_b1, busy_b0, done_b1, done_b0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_32x32 #(.BYPASS(1)) dut_b1 (
        .clk(clk), .reset(reset),
        .ReadData1(rd1_b1), .ReadData2(rd2_b1),
        .WriteData(WriteData),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .WriteRegister(WriteRegister), .RegWrite(RegWrite),
        .clear_req(clear_req), .busy(busy_b1), .clear_done(done_b1)
    );

    regfile_32x32 #(.BYPASS(0)) dut_b0 (
        .clk(clk), .reset(reset),
        .ReadData1(rd1_b0), .ReadData2(rd2_b0),
        .WriteData(WriteData),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .WriteRegister(WriteRegister), .RegWrite(RegWrite),
        .clear_req(clear_req), .busy(busy_b0), .clear_done(done_b0)
    );

    // Behavioural model: register contents plus "registers still to clear".
    logic [31:0] mem [0:31];
    int          m_left = 0;
    logic        m_done = 1'b0;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
            m_left <= 0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                mem[32 - m_left] <= 32'd0;
                m_left <= m_left - 1;
                if (m_left == 1) m_done <= 1'b1;
            end else begin
                if (RegWrite && WriteRegister != 5'd0) mem[WriteRegister] <= WriteData;
                if (clear_req) m_left <= 31;
            end
        end
    end

    function automatic logic [31:0] model_read(input logic [4:0] addr, input bit fwd);
        if (addr == 5'd0) return 32'd0;
        if (fwd && RegWrite && m_left == 0 && WriteRegister == addr) return WriteData;
        return mem[addr];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %08h expected %08h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("b1_rd1", rd1_b1, model_read(ReadRegister1, 1'b1));
        chk("b1_rd2", rd2_b1, model_read(ReadRegister2, 1'b1));
        chk("b0_rd1", rd1_b0, model_read(ReadRegister1, 1'b0));
        chk("b0_rd2", rd2_b0, model_read(ReadRegister2, 1'b0));
        chk("b1_busy", 32'(busy_b1), 32'(m_left != 0));
        chk("b0_busy", 32'(busy_b0), 32'(m_left != 0));
        chk("b1_done", 32'(done_b1), 32'(m_done));
        chk("b0_done", 32'(done_b0), 32'(m_done));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        RegWrite = 1'b1; WriteRegister = a; WriteData = d;
        tick(1);
        RegWrite = 1'b0;
    endtask

    int n;
    int k;

    initial begin
        tick(2);
        reset = 1'b0;
        #1;
        chk("reset_busy", 32'(busy_b1), 32'd0);
        chk("reset_done", 32'(done_b1), 32'd0);

        // r5 write then both ports on the same address
        write_reg(5'd5, 32'hDEADBEEF);
        ReadRegister1 = 5'd5; ReadRegister2 = 5'd5; #1;
        chk("r5_port1", rd1_b1, 32'hDEADBEEF);
        chk("r5_port2", rd2_b1, 32'hDEADBEEF);
        ReadRegister1 = 5'd4; ReadRegister2 = 5'd6; #1;
        chk("r4_zero", rd1_b1, 32'd0);
        chk("r6_zero", rd2_b1, 32'd0);

        // r0 ignores writes
        write_reg(5'd0, 32'hFFFFFFFF);
        ReadRegister1 = 5'd0; ReadRegister2 = 5'd0; #1;
        chk("r0_port1", rd1_b1, 32'd0);
        chk("r0_port2_b0", rd2_b0, 32'd0);
        ReadRegister1 = 5'd5; #1;
        chk("r5_kept", rd1_b0, 32'hDEADBEEF);

        // forwarding
        write_reg(5'd7, 32'h11111111);
        RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 32'h12345678; ReadRegister1 = 5'd7; #1;
        chk("bypass_on", rd1_b1, 32'h12345678);
        chk("bypass_off", rd1_b0, 32'h11111111);
        tick(1);
        RegWrite = 1'b0; #1;
        chk("after_b1", rd1_b1, 32'h12345678);
        chk("after_b0", rd1_b0, 32'h12345678);

        // full sweep with a lost write
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i));
        clear_req = 1'b1;
        tick(1);
        clear_req = 1'b0;
        n = 0;
        while (busy_b1 && n < 40) begin
            n++;
            if (n == 2) begin
                RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 32'hA5A5A5A5;
            end else begin
                RegWrite = 1'b0;
            end
            tick(1);
        end
        RegWrite = 1'b0;
        chk("sweep_len", 32'(n), 32'd31);
        chk("done_pulse", 32'(done_b1), 32'd1);
        tick(1);
        chk("done_low", 32'(done_b1), 32'd0);
        for (int a = 0; a < 32; a++) begin
            ReadRegister1 = 5'(a); ReadRegister2 = 5'(31 - a); #1;
            chk("swept_p1", rd1_b1, 32'd0);
            chk("swept_p2", rd2_b0, 32'd0);
            tick(1);
        end

        // async reset mid-sweep
        for (int i = 1; i < 32; i++) write_reg(5'(i), $urandom | 32'h1);
        ReadRegister1 = 5'd20; ReadRegister2 = 5'd31;
        clear_req = 1'b1;
        tick(1);
        clear_req = 1'b0;
        tick(9);
        #2;
        reset = 1'b1; #1;
        chk("rst_busy", 32'(busy_b1), 32'd0);
        chk("rst_rd1", rd1_b1, 32'd0);
        chk("rst_rd2", rd2_b0, 32'd0);
        tick(1);
        reset = 1'b0;
        k = 0;
        for (int i = 0; i < 3; i++) begin
            if (done_b1 || done_b0) k++;
            tick(1);
        end
        chk("rst_no_done", 32'(k), 32'd0);
        write_reg(5'd9, 32'h0000BEEF);
        ReadRegister1 = 5'd9; #1;
        chk("r9_readback", rd1_b1, 32'h0000BEEF);

        // clear_req held through a sweep
        clear_req = 1'b1;
        tick(1);
        n = 0;
        while (busy_b1 && n < 40) begin
            n++;
            tick(1);
        end
        chk("held_len1", 32'(n), 32'd31);
        chk("held_done", 32'(done_b1), 32'd1);
        tick(1);
        clear_req = 1'b0;
        chk("held_restart", 32'(busy_b1), 32'd1);
        chk("held_done_low", 32'(done_b1), 32'd0);
        n = 0;
        while (busy_b1 && n < 40) begin
            n++;
            tick(1);
        end
        chk("held_len2", 32'(n), 32'd31);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            RegWrite      = ($urandom_range(0, 1) == 1);
            WriteRegister = 5'($urandom_range(0, 31));
            WriteData     = $urandom;
            ReadRegister1 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom_range(0, 31));
            ReadRegister2 = ($urandom_range(0, 3) == 0) ? ReadRegister1 : 5'($urandom_range(0, 31));
            clear_req     = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 999) == 0) begin
                #3 reset = 1'b1;
                tick(1);
                reset = 1'b0;
            end else begin
                tick(1);
            end
        end
        RegWrite = 1'b0;
        clear_req = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
